cmd_sequencer: RTL

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_seq_pkg.sv | 64 ++++++
 rtl/cmd_tx_shifter.sv | 44 ++++
 rtl/cmd_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_seq_pkg
// Description : Shared types and constants for the command sequencer: FSM
//               state encoding, command byte values, argument byte counts
//               and the identification string returned by 'I'.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARG     = 3'd1,
    ST_EXEC    = 3'd2,
    ST_PULSE_C = 3'd3,
    ST_GAP     = 3'd4,
    ST_PULSE_I = 3'd5,
    ST_SEND    = 3'd6
  } state_t;

  // Command bytes (ASCII)
  localparam logic [7:0] CMD_SET_ADDR   = 8'h41; // 'A'
  localparam logic [7:0] CMD_SET_DATA   = 8'h42; // 'B'
  localparam logic [7:0] CMD_SET_CW     = 8'h4D; // 'M'
  localparam logic [7:0] CMD_OFF_CW     = 8'h4F; // 'O'
  localparam logic [7:0] CMD_FLOAT      = 8'h66; // 'f'
  localparam logic [7:0] CMD_RD_ADDR    = 8'h61; // 'a'
  localparam logic [7:0] CMD_RD_DATA    = 8'h62; // 'b'
  localparam logic [7:0] CMD_RD_FLAGS   = 8'h73; // 's'
  localparam logic [7:0] CMD_RD_OPCODE  = 8'h72; // 'r'
  localparam logic [7:0] CMD_IDENT      = 8'h49; // 'I'
  localparam logic [7:0] CMD_BREAK      = 8'h52; // 'R'
  localparam logic [7:0] CMD_CLK        = 8'h63; // 'c'
  localparam logic [7:0] CMD_ICLK       = 8'h43; // 'C'
  localparam logic [7:0] CMD_TICK       = 8'h54; // 'T'
  localparam logic [7:0] CMD_NOP        = 8'h4E; // 'N'
  localparam logic [7:0] CMD_NOP_FF     = 8'hFF;
  localparam logic [7:0] CMD_QUIT       = 8'h51; // 'Q'

  // "HwSeqVM", first character in the least significant byte
  localparam logic [63:0] ID_STRING  = 64'h004D_5671_6553_7748;
  localparam logic [3:0]  ID_LEN     = 4'd7;
  // "#BRK", first character in the least significant byte
  localparam logic [63:0] BRK_STRING = 64'h0000_0000_4B52_4223;
  localparam logic [3:0]  BRK_LEN    = 4'd4;

  // Number of argument bytes following a command byte
  function automatic logic [2:0] arg_count(input logic [7:0] cmd);
    logic [2:0] n;
    n = 3'd0;
    case (cmd)
      CMD_SET_ADDR:  n = 3'd2;
      CMD_SET_DATA:  n = 3'd1;
      CMD_SET_CW:    n = 3'd4;
      CMD_OFF_CW:    n = 3'd4;
      CMD_RD_OPCODE: n = 3'd4;
      default:       n = 3'd0;
    endcase
    return n;
  endfunction

endpackage : cmd_seq_pkg
`default_nettype wire

// File: rtl/cmd_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : cmd_tx_shifter
// Description : Response serialiser. Loads up to eight bytes plus a byte
//               count and presents them least significant byte first on a
//               valid/ready stream. Data is taken straight from the shift
//               register, so it cannot change while the consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_tx_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic [3:0]  load_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last
);

  logic [63:0] shift_reg;
  logic [3:0]  remaining;

  // Load a new response or advance one byte per accepted transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      remaining <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      remaining <= load_len;
    end else if (tx_valid && tx_ready) begin
      shift_reg <= {8'h00, shift_reg[63:8]};
      remaining <= remaining - 4'd1;
    end
  end

  assign tx_data  = shift_reg[7:0];
  assign tx_valid = (remaining != 4'd0);
  assign tx_last  = (remaining == 4'd1);

endmodule : cmd_tx_shifter
`default_nettype wire

// File: rtl/cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cmd_sequencer
// Description : Byte-stream command sequencer driving a CPU under test. It
//               decodes command bytes with little-endian arguments, drives
//               the data/address buses and control word, generates CPU clock
//               pulses and returns observation data as response bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter logic [31:0] DEFAULT_CW = 32'h0000_0000,
  parameter int          PULSE_LEN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  // command stream
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  // response stream
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  // CPU drive
  output logic [31:0] control_word,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [15:0] addr_out,
  output logic        addr_oe,
  // CPU observation
  input  logic [7:0]  main_bus_in,
  input  logic [15:0] addr_bus_in,
  input  logic [3:0]  flags_in,
  input  logic [7:0]  opcode_in,
  // CPU clocking and reset
  output logic        cpu_clk,
  output logic        cpu_iclk,
  output logic        cpu_rst,
  // status
  output logic        busy,
  output logic        err_unknown
);

  // Counter reload: pulse stays high for PULSE_LEN cycles (clamped to >= 1)
  localparam logic [15:0] PULSE_LOAD = (PULSE_LEN > 1) ? 16'(PULSE_LEN - 1) : 16'd0;

  state_t      state;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic [2:0]  arg_idx;
  logic [15:0] pulse_cnt;
  logic        rst_hold;

  logic [63:0] resp_data;
  logic [3:0]  resp_len;
  logic        resp_load;
  logic        tx_last;

  // Build the response for the current command from the live observation
  // inputs; it is captured by the shifter at the end of the EXEC cycle.
  always_comb begin
    resp_data = '0;
    resp_len  = 4'd0;
    case (cmd)
      CMD_RD_ADDR: begin
        resp_data = {48'h0, addr_bus_in};
        resp_len  = 4'd2;
      end
      CMD_RD_DATA: begin
        resp_data = {56'h0, main_bus_in};
        resp_len  = 4'd1;
      end
      CMD_RD_FLAGS: begin
        resp_data = {56'h0, 4'h0, flags_in};
        resp_len  = 4'd1;
      end
      CMD_RD_OPCODE: begin
        resp_data = {56'h0, opcode_in};
        resp_len  = 4'd1;
      end
      CMD_IDENT: begin
        resp_data = ID_STRING;
        resp_len  = ID_LEN;
      end
      CMD_BREAK: begin
        resp_data = BRK_STRING;
        resp_len  = BRK_LEN;
      end
      default: begin
        resp_data = '0;
        resp_len  = 4'd0;
      end
    endcase
  end

  assign resp_load = (state == ST_EXEC) && (resp_len != 4'd0);

  cmd_tx_shifter u_tx_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (resp_load),
    .load_data (resp_data),
    .load_len  (resp_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last)
  );

  assign busy = (state != ST_IDLE);

  // Command FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd          <= '0;
      arg          <= '0;
      arg_idx      <= '0;
      pulse_cnt    <= '0;
      control_word <= DEFAULT_CW;
      data_out     <= '0;
      data_oe      <= 1'b0;
      addr_out     <= '0;
      addr_oe      <= 1'b0;
      cpu_clk      <= 1'b0;
      cpu_iclk     <= 1'b0;
      rx_ready     <= 1'b0;
      err_unknown  <= 1'b0;
      cpu_rst      <= 1'b1;
      rst_hold     <= 1'b1;
    end else begin
      // CPU reset is stretched one cycle past the end of rst
      cpu_rst     <= rst_hold;
      rst_hold    <= 1'b0;
      err_unknown <= 1'b0;

      case (state)
        ST_IDLE: begin
          rx_ready <= 1'b1;
          if (rx_valid && rx_ready) begin
            cmd     <= rx_data;
            arg     <= '0;
            arg_idx <= '0;
            if (arg_count(rx_data) != 3'd0) begin
              state <= ST_ARG;
            end else begin
              state    <= ST_EXEC;
              rx_ready <= 1'b0;
            end
          end
        end

        ST_ARG: begin
          if (rx_valid && rx_ready) begin
            arg[{arg_idx[1:0], 3'b000} +: 8] <= rx_data;
            arg_idx <= arg_idx + 3'd1;
            if ((arg_idx + 3'd1) == arg_count(cmd)) begin
              state    <= ST_EXEC;
              rx_ready <= 1'b0;
            end
          end
        end

        ST_EXEC: begin
          // Most commands complete here and go straight back to IDLE
          state    <= ST_IDLE;
          rx_ready <= 1'b1;
          case (cmd)
            CMD_SET_ADDR: begin
              addr_out <= arg[15:0];
              addr_oe  <= 1'b1;
            end
            CMD_SET_DATA: begin
              data_out <= arg[7:0];
              data_oe  <= 1'b1;
            end
            CMD_FLOAT: begin
              data_oe <= 1'b0;
              addr_oe <= 1'b0;
            end
            CMD_OFF_CW: begin
              data_oe      <= 1'b0;
              addr_oe      <= 1'b0;
              control_word <= arg;
            end
            CMD_SET_CW: begin
              control_word <= arg;
            end
            CMD_RD_ADDR, CMD_RD_DATA, CMD_RD_FLAGS,
            CMD_RD_OPCODE, CMD_IDENT, CMD_BREAK: begin
              state    <= ST_SEND;
              rx_ready <= 1'b0;
            end
            CMD_CLK, CMD_TICK: begin
              state     <= ST_PULSE_C;
              rx_ready  <= 1'b0;
              cpu_clk   <= 1'b1;
              pulse_cnt <= PULSE_LOAD;
            end
            CMD_ICLK: begin
              state     <= ST_PULSE_I;
              rx_ready  <= 1'b0;
              cpu_iclk  <= 1'b1;
              pulse_cnt <= PULSE_LOAD;
            end
            CMD_NOP, CMD_NOP_FF, CMD_QUIT: begin
              state <= ST_IDLE;
            end
            default: begin
              err_unknown <= 1'b1;
            end
          endcase
        end

        ST_PULSE_C: begin
          if (pulse_cnt == 16'd0) begin
            cpu_clk <= 1'b0;
            if (cmd == CMD_TICK) begin
              state <= ST_GAP;
            end else begin
              state    <= ST_IDLE;
              rx_ready <= 1'b1;
            end
          end else begin
            pulse_cnt <= pulse_cnt - 16'd1;
          end
        end

        // One cycle with both clocks low keeps the two pulses apart
        ST_GAP: begin
          state     <= ST_PULSE_I;
          cpu_iclk  <= 1'b1;
          pulse_cnt <= PULSE_LOAD;
        end

        ST_PULSE_I: begin
          if (pulse_cnt == 16'd0) begin
            cpu_iclk <= 1'b0;
            state    <= ST_IDLE;
            rx_ready <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt - 16'd1;
          end
        end

        ST_SEND: begin
          if (tx_valid && tx_ready && tx_last) begin
            state    <= ST_IDLE;
            rx_ready <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          rx_ready <= 1'b1;
          cpu_clk  <= 1'b0;
          cpu_iclk <= 1'b0;
        end
      endcase
    end
  end

endmodule : cmd_sequencer
`default_nettype wire
